// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and forward key-schedule helpers for the AES-128 inverse core.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        KEXP,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // Forward S-box, entry n sits at index n (row-major FIPS-197 table).
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module aes_inv_sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);

    localparam logic [0:255][7:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign result = INV_SBOX_TABLE[data];

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 decryption, one round per clock; round keys are walked forward to K10
// and then stepped back to K0 on the fly, so no key schedule is stored.
module aes_inv_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic         done,
    output logic [127:0] plaintext
);

    state_t       state;
    state_t       state_next;
    logic [3:0]   cnt;
    logic [127:0] rk;
    logic [127:0] st;

    logic [31:0]  w0, w1, w2, w3;
    logic         fwd_mode;
    logic [31:0]  sbox_word;
    logic [31:0]  sw;
    logic [7:0]   rc;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  b0, b1, b2, b3;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;

    logic [0:15][7:0] st_bytes;
    logic [0:15][7:0] shifted;
    logic [0:15][7:0] unsub;
    logic [0:3][31:0] added;
    logic [0:3][31:0] round_out;

    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_mul2(b);
        x4 = gf_mul2(x2);
        x8 = gf_mul2(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? b  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {
            gf_mul_const(a0, 4'he) ^ gf_mul_const(a1, 4'hb) ^ gf_mul_const(a2, 4'hd) ^ gf_mul_const(a3, 4'h9),
            gf_mul_const(a0, 4'h9) ^ gf_mul_const(a1, 4'he) ^ gf_mul_const(a2, 4'hb) ^ gf_mul_const(a3, 4'hd),
            gf_mul_const(a0, 4'hd) ^ gf_mul_const(a1, 4'h9) ^ gf_mul_const(a2, 4'he) ^ gf_mul_const(a3, 4'hb),
            gf_mul_const(a0, 4'hb) ^ gf_mul_const(a1, 4'hd) ^ gf_mul_const(a2, 4'h9) ^ gf_mul_const(a3, 4'he)
        };
    endfunction

    // One SubWord(RotWord()) serves both directions: w3 going forward, w3^w2 going back.
    assign {w0, w1, w2, w3} = rk;
    assign fwd_mode  = (state == IDLE) || ((state == KEXP) && (cnt <= NR));
    assign sbox_word = fwd_mode ? w3 : (w3 ^ w2);
    assign sw        = sub_word(rot_word(sbox_word));
    assign rc        = rcon(((state == KEXP) && (cnt > NR)) ? NR : cnt);

    always_comb begin
        f0 = w0 ^ sw ^ {rc, 24'h000000};
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        b3 = w3 ^ w2;
        b2 = w2 ^ w1;
        b1 = w1 ^ w0;
        b0 = w0 ^ sw ^ {rc, 24'h000000};
        rk_fwd = {f0, f1, f2, f3};
        rk_inv = {b0, b1, b2, b3};
    end

    assign st_bytes = st;

    // Byte 4*c+r is row r of column c; InvShiftRows moves row r right by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[4*c+r] = st_bytes[4*((c-r+4)%4)+r];
            aes_inv_sbox u_inv_sbox (
                .data   (shifted[4*c+r]),
                .result (unsub[4*c+r])
            );
        end
        assign round_out[c] = inv_mix_column(added[c]);
    end

    assign added = unsub ^ rk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (cnt == 4'd1) state_next = KEXP;
                KEXP:    if (cnt > NR)    state_next = ROUND;
                ROUND:   if (cnt == 4'd1) state_next = FINAL;
                FINAL:   state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // IDLE only launches when a load has primed cnt to 1, so reset alone never starts a run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rk        <= '0;
            st        <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            plaintext <= '0;
        end else if (load) begin
            rk   <= key;
            st   <= cyphertext;
            cnt  <= 4'd1;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cnt == 4'd1) begin
                        rk  <= rk_fwd;
                        cnt <= cnt + 4'd1;
                    end
                end
                KEXP: begin
                    if (cnt <= NR) begin
                        rk  <= rk_fwd;
                        cnt <= cnt + 4'd1;
                    end else begin
                        st  <= st ^ rk;
                        rk  <= rk_inv;
                        cnt <= NR - 4'd1;
                    end
                end
                ROUND: begin
                    st  <= round_out;
                    rk  <= rk_inv;
                    cnt <= cnt - 4'd1;
                end
                FINAL: begin
                    plaintext <= added;
                    done      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_core.sv
// Self-checking bench for aes_inv_core: FIPS-197 vectors, key probes, abort, async reset,
// output hold and a random round trip against a forward AES-128 reference model.
module tb_aes_inv_core;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load;
    logic [127:0] key;
    logic [127:0] cyphertext;
    logic         done;
    logic [127:0] plaintext;

    int           checks = 0;
    int           failures = 0;
    logic [127:0] sb_q[$];
    logic [127:0] last_pt;
    logic [7:0]   sbox_ref [256];

    always #5 clk = ~clk;

    aes_inv_core dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .key        (key),
        .cyphertext (cyphertext),
        .done       (done),
        .plaintext  (plaintext)
    );

    // Reference model: forward AES-128 with an S-box derived from GF(2^8) inversion.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]      w [44];
        logic [31:0]      t;
        logic [7:0]       rc;
        logic [0:15][7:0] a;
        logic [0:15][7:0] b;
        logic [7:0]       c0, c1, c2, c3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]], sbox_ref[t[31:24]]}
                    ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        a = p ^ {w[0], w[1], w[2], w[3]};
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) a[i] = sbox_ref[a[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                    b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
                    b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
                    b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
                    b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
                end
            end
            a = b ^ {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
        end
        return a;
    endfunction

    task automatic start_run(input logic [127:0] k, input logic [127:0] c, input logic [127:0] exp_pt);
        @(negedge clk);
        load = 1'b1;
        key = k;
        cyphertext = c;
        sb_q.push_back(exp_pt);
        @(negedge clk);
        load = 1'b0;
        key = ~k;
        cyphertext = ~c;
    endtask

    task automatic wait_for_done(output int lat);
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (plaintext !== 128'h0) begin
            failures++;
            $display("FAIL reset_pt: got %h expected 0", plaintext);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_vector(input string name, input logic [127:0] k,
                               input logic [127:0] c, input logic [127:0] p);
        int lat;
        logic [127:0] exp_pt;
        start_run(k, c, p);
        wait_for_done(lat);
        checks++;
        if (lat != 21) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected 21", name, lat);
        end
        exp_pt = sb_q.pop_front();
        checks++;
        if (plaintext !== exp_pt) begin
            failures++;
            $display("FAIL %s_pt: got %h expected %h", name, plaintext, exp_pt);
        end
        last_pt = exp_pt;
    endtask

    task automatic test_key_probe();
        logic [127:0] exp_pt;
        start_run(KEY_B, CT_B, PT_B);
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            if (cyc == 10) begin
                checks++;
                if (dut.rk !== K10_B) begin
                    failures++;
                    $display("FAIL probe_k10: got %h expected %h", dut.rk, K10_B);
                end
            end
            if (cyc == 20) begin
                checks++;
                if (dut.rk !== KEY_B) begin
                    failures++;
                    $display("FAIL probe_k0: got %h expected %h", dut.rk, KEY_B);
                end
            end
        end
        exp_pt = sb_q.pop_front();
        checks++;
        if (done !== 1'b1 || plaintext !== exp_pt) begin
            failures++;
            $display("FAIL probe_pt: got done=%b pt=%h expected done=1 pt=%h", done, plaintext, exp_pt);
        end
        last_pt = exp_pt;
    endtask

    task automatic test_abort();
        int seen_done = 0;
        logic [127:0] prev_pt = last_pt;
        start_run(KEY_B, CT_B, PT_B);
        void'(sb_q.pop_back());
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done++;
        end
        load = 1'b1;
        @(negedge clk);
        if (done !== 1'b0) seen_done++;
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL abort_done_low: got %0d high samples expected 0", seen_done);
        end
        checks++;
        if (plaintext !== prev_pt) begin
            failures++;
            $display("FAIL abort_pt_kept: got %h expected %h", plaintext, prev_pt);
        end
        test_vector("abort_run2", KEY_C, CT_C, PT_C);
    endtask

    task automatic test_async_reset();
        start_run(KEY_B, CT_B, PT_B);
        void'(sb_q.pop_back());
        repeat (14) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_done: got %b expected 0", done);
        end
        checks++;
        if (plaintext !== 128'h0) begin
            failures++;
            $display("FAIL async_reset_pt: got %h expected 0", plaintext);
        end
        @(negedge clk);
        reset_n = 1'b1;
        test_vector("after_reset", KEY_B, CT_B, PT_B);
    endtask

    task automatic test_hold();
        int bad = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (done !== 1'b1 || plaintext !== last_pt) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold: got %0d bad cycles expected 0 (pt=%h want %h)", bad, plaintext, last_pt);
        end
    endtask

    task automatic test_random_round_trip();
        logic [127:0] k;
        logic [127:0] p;
        for (int n = 0; n < 1000; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            test_vector("random", k, encrypt(k, p), p);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        load = 1'b1;
        key = '0;
        cyphertext = '0;
        last_pt = '0;
        build_sbox();
        test_reset();
        test_vector("fips_b", KEY_B, CT_B, PT_B);
        test_vector("fips_c1", KEY_C, CT_C, PT_C);
        test_key_probe();
        test_abort();
        test_async_reset();
        test_hold();
        test_random_round_trip();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
